// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mult_sequencer
// Purpose  : Execute-stage multiply controller: issues MULT/MULTU to a
//            fixed-latency multiplier, owns HI/LO and raises HI/LO stalls.
// Options  : MULT_STALL_CNT_EN adds the saturating o_stall_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module mult_sequencer #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_issue_valid,
    input  logic                 i_issue_signed,
    input  logic                 i_flush,
    input  logic [WIDTH-1:0]     i_srca,
    input  logic [WIDTH-1:0]     i_srcb,
    input  logic                 i_mf_req,
    input  logic                 i_mf_sel,
    input  logic                 i_wr_hi,
    input  logic                 i_wr_lo,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic [2*WIDTH-1:0]   i_mult_product,
    output logic                 o_mult_start,
    output logic                 o_mult_signed,
    output logic [WIDTH-1:0]     o_mult_a,
    output logic [WIDTH-1:0]     o_mult_b,
    output logic                 o_busy,
    output logic                 o_stall,
    output logic                 o_done,
    output logic [WIDTH-1:0]     o_mf_data
`ifdef MULT_STALL_CNT_EN
    ,
    output logic [15:0]          o_stall_cycles
`endif
);

    localparam logic [0:0]       S_IDLE     = 1'b0;
    localparam logic [0:0]       S_RUN      = 1'b1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic             r_start;
    logic             r_done;

    logic             w_busy;
    logic             w_stall;
    logic             w_accept;
    logic             w_capture;
    logic             w_mt_ok;

    assign w_accept  = (r_state == S_IDLE) & i_issue_valid & ~i_flush;
    assign w_capture = (r_state == S_RUN) & (r_cnt == '0);
    // MT writes land only when no multiply owns HI/LO
    assign w_mt_ok   = ~w_busy & ~i_flush;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_nxt = S_RUN;
            S_RUN:   if (w_capture) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_busy  = (r_state == S_RUN);
        w_stall = w_busy & (i_issue_valid | i_mf_req | i_wr_hi | i_wr_lo);
    end

    // ------------------------------------------------------------------
    // Latency counter, operand latches and strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_start <= w_accept;
            r_done  <= w_capture;
            if (w_accept) begin
                r_cnt    <= C_CNT_LOAD;
                r_a      <= i_srca;
                r_b      <= i_srcb;
                r_signed <= i_issue_signed;
            end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Architectural HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_capture) begin
            r_hi <= i_mult_product[2*WIDTH-1:WIDTH];
            r_lo <= i_mult_product[WIDTH-1:0];
        end else if (w_mt_ok) begin
            if (i_wr_hi) r_hi <= i_wr_data;
            if (i_wr_lo) r_lo <= i_wr_data;
        end
    end

`ifdef MULT_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

    assign o_mult_start  = r_start;
    assign o_mult_signed = r_signed;
    assign o_mult_a      = r_a;
    assign o_mult_b      = r_b;
    assign o_busy        = w_busy;
    assign o_stall       = w_stall;
    assign o_done        = r_done;
    assign o_mf_data     = i_mf_sel ? r_hi : r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// Testbench for mult_sequencer: directed scenarios plus randomized
// multiplies and MT writes checked against a simple HI/LO reference model.
module tb_mult_sequencer;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 4;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               issue_valid, issue_signed, flush;
    logic [WIDTH-1:0]   srca, srcb;
    logic               mf_req, mf_sel, wr_hi, wr_lo;
    logic [WIDTH-1:0]   wr_data;
    logic [2*WIDTH-1:0] mult_product;
    logic               mult_start, mult_signed;
    logic [WIDTH-1:0]   mult_a, mult_b;
    logic               busy, stall, done;
    logic [WIDTH-1:0]   mf_data;
`ifdef MULT_STALL_CNT_EN
    logic [15:0]        stall_cycles;
`endif

    mult_sequencer #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_issue_valid  (issue_valid),
        .i_issue_signed (issue_signed),
        .i_flush        (flush),
        .i_srca         (srca),
        .i_srcb         (srcb),
        .i_mf_req       (mf_req),
        .i_mf_sel       (mf_sel),
        .i_wr_hi        (wr_hi),
        .i_wr_lo        (wr_lo),
        .i_wr_data      (wr_data),
        .i_mult_product (mult_product),
        .o_mult_start   (mult_start),
        .o_mult_signed  (mult_signed),
        .o_mult_a       (mult_a),
        .o_mult_b       (mult_b),
        .o_busy         (busy),
        .o_stall        (stall),
        .o_done         (done),
        .o_mf_data      (mf_data)
`ifdef MULT_STALL_CNT_EN
        ,
        .o_stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference state
    logic [WIDTH-1:0]   m_hi = '0;
    logic [WIDTH-1:0]   m_lo = '0;
    logic [2*WIDTH-1:0] exp_prod = '0;

    // Multiplier model: product valid only in the cycle before capture
    int mcnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          mcnt <= 0;
        else if (mult_start) mcnt <= 1;
        else if (mcnt != 0)  mcnt <= (mcnt == LATENCY - 1) ? 0 : mcnt + 1;
    end
    assign mult_product = (mcnt == LATENCY - 1) ? exp_prod : 64'hA5A5_5A5A_0F0F_F0F0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks++;
            if (stall !== (busy & (issue_valid | mf_req | wr_hi | wr_lo))) begin
                n_fail++;
                $error("FAIL mon_stall_eq: stall %0b busy %0b", stall, busy);
            end else begin
                n_pass++;
            end
            n_checks++;
            if ((mult_start === 1'b1) && (busy !== 1'b1)) begin
                n_fail++;
                $error("FAIL mon_start_busy: mult_start without busy");
            end else begin
                n_pass++;
            end
            n_checks++;
            if ((done === 1'b1) && (busy !== 1'b0)) begin
                n_fail++;
                $error("FAIL mon_done_idle: done while busy");
            end else begin
                n_pass++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    `define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        if (s) return longint'(int'(a)) * longint'(int'(b));
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0; issue_signed = 1'b0; flush = 1'b0;
        srca = '0; srcb = '0; mf_req = 1'b0; mf_sel = 1'b0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    endtask

    task automatic chk_hilo(input string tag);
        mf_sel = 1'b1; #1;
        `CHK({tag, "_hi"}, mf_data, m_hi);
        mf_sel = 1'b0; #1;
        `CHK({tag, "_lo"}, mf_data, m_lo);
    endtask

    // One full multiply, with an optional MF request stalled across RUN
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic mfd);
        logic [63:0] p;
        p = ref_prod(a, b, s);
        issue_valid = 1'b1; issue_signed = s; srca = a; srcb = b; #1;
        `CHK("issue_stall_idle", stall, 0);
        tick();
        exp_prod = p;
        issue_valid = 1'b0; srca = $urandom; srcb = $urandom; issue_signed = ~s;
        mf_req = mfd; mf_sel = 1'($urandom_range(0, 1)); #1;
        `CHK("start_pulse", mult_start, 1);
        `CHK("busy_after_e0", busy, 1);
        `CHK("mult_a", mult_a, a);
        `CHK("mult_b", mult_b, b);
        `CHK("mult_signed", mult_signed, s);
        for (int k = 1; k < LATENCY; k++) begin
            tick();
            `CHK("start_low", mult_start, 0);
            `CHK("busy_run", busy, 1);
            `CHK("done_low_run", done, 0);
            `CHK("stall_run", stall, mfd);
            `CHK("mult_a_stable", mult_a, a);
        end
        tick();
        `CHK("busy_fall", busy, 0);
        `CHK("done_pulse", done, 1);
        `CHK("stall_after", stall, 0);
        m_hi = p[63:32];
        m_lo = p[31:0];
        mf_req = 1'b0;
        chk_hilo("capture");
        tick();
        `CHK("done_single", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] a1, b1, a2, b2, d;
        logic [63:0] p1, p2;
        int stalls;
        int done_seen;
        logic wh, wl, fl;

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        `CHK("rst_busy", busy, 0);
        `CHK("rst_start", mult_start, 0);
        `CHK("rst_done", done, 0);
        `CHK("rst_signed", mult_signed, 0);
        `CHK("rst_a", mult_a, 0);
        `CHK("rst_b", mult_b, 0);
        `CHK("rst_stall", stall, 0);
        chk_hilo("rst");
        rst_n = 1'b1;
        tick();

        // Signed -2 * 3
        run_mult(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        `CHK("signed_hi_const", m_hi, 32'hFFFF_FFFF);
        mf_sel = 1'b0; #1;
        `CHK("signed_lo_const", mf_data, 32'hFFFF_FFFA);

        // MFLO issued one cycle after the multiply
        a1 = $urandom; b1 = $urandom;
        issue_valid = 1'b1; srca = a1; srcb = b1; issue_signed = 1'b0;
        tick();
        exp_prod = ref_prod(a1, b1, 1'b0);
        issue_valid = 1'b0;
        tick();
        mf_req = 1'b1; mf_sel = 1'b0; #1;
        stalls = 0;
        while (stall && stalls < 10) begin
            stalls++;
            tick();
        end
        `CHK("mflo_stall_cycles", stalls, 3);
        `CHK("mflo_done", done, 1);
        m_hi = exp_prod[63:32];
        m_lo = exp_prod[31:0];
        `CHK("mflo_new_lo", mf_data, m_lo);
        mf_req = 1'b0;
        tick();

        // Back-to-back: second issue held from E0+1
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        p1 = ref_prod(a1, b1, 1'b1);
        p2 = ref_prod(a2, b2, 1'b0);
        issue_valid = 1'b1; issue_signed = 1'b1; srca = a1; srcb = b1;
        tick();
        exp_prod = p1;
        issue_signed = 1'b0; srca = a2; srcb = b2; #1;
        for (int k = 0; k < LATENCY; k++) begin
            `CHK("b2b_stall", stall, 1);
            `CHK("b2b_a_hold", mult_a, a1);
            tick();
        end
        `CHK("b2b_busy_fall", busy, 0);
        `CHK("b2b_stall_fall", stall, 0);
        `CHK("b2b_no_start_capture", mult_start, 0);
        m_hi = p1[63:32];
        m_lo = p1[31:0];
        chk_hilo("b2b_first");
        tick();
        exp_prod = p2;
        issue_valid = 1'b0;
        `CHK("b2b_second_start", mult_start, 1);
        `CHK("b2b_second_a", mult_a, a2);
        `CHK("b2b_second_b", mult_b, b2);
        repeat (LATENCY) tick();
        `CHK("b2b_second_done", done, 1);
        m_hi = p2[63:32];
        m_lo = p2[31:0];
        chk_hilo("b2b_second");
        tick();

        // MT writes and flush
        wr_hi = 1'b1; wr_data = 32'h1234_5678; #1;
        `CHK("mthi_no_stall", stall, 0);
        tick();
        wr_hi = 1'b0;
        m_hi = 32'h1234_5678;
        chk_hilo("mthi");
        wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF; flush = 1'b1;
        tick();
        wr_hi = 1'b0; flush = 1'b0;
        chk_hilo("mthi_flushed");
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        m_hi = 32'hCAFE_F00D;
        m_lo = 32'hCAFE_F00D;
        chk_hilo("mt_both");
        issue_valid = 1'b1; flush = 1'b1; srca = 32'd7; srcb = 32'd9;
        tick();
        issue_valid = 1'b0; flush = 1'b0;
        `CHK("flush_issue_no_start", mult_start, 0);
        `CHK("flush_issue_no_busy", busy, 0);
        tick();

        // Reset at E0+2
        issue_valid = 1'b1; srca = $urandom; srcb = $urandom;
        tick();
        exp_prod = ref_prod(srca, srcb, issue_signed);
        issue_valid = 1'b0;
        repeat (2) tick();
        mf_req = 1'b1;
        rst_n = 1'b0; #1;
        m_hi = '0;
        m_lo = '0;
        `CHK("midrst_busy", busy, 0);
        `CHK("midrst_stall", stall, 0);
        chk_hilo("midrst");
        mf_req = 1'b0;
        #1 rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) done_seen++;
        end
        `CHK("midrst_no_done", done_seen, 0);
        chk_hilo("midrst_after");

        // Randomized multiplies, MT writes and flushed issues
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: run_mult($urandom, $urandom, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
                1: begin
                    d  = $urandom;
                    wh = 1'($urandom_range(0, 1));
                    wl = 1'($urandom_range(0, 1));
                    fl = ($urandom_range(0, 3) == 0);
                    wr_hi = wh; wr_lo = wl; wr_data = d; flush = fl; #1;
                    `CHK("rnd_mt_stall", stall, 0);
                    tick();
                    wr_hi = 1'b0; wr_lo = 1'b0; flush = 1'b0;
                    if (!fl) begin
                        if (wh) m_hi = d;
                        if (wl) m_lo = d;
                    end
                    chk_hilo("rnd_mt");
                end
                default: begin
                    issue_valid = 1'b1; flush = 1'b1; srca = $urandom; srcb = $urandom;
                    tick();
                    issue_valid = 1'b0; flush = 1'b0;
                    `CHK("rnd_flush_no_start", mult_start, 0);
                    chk_hilo("rnd_flush");
                end
            endcase
        end

`ifdef MULT_STALL_CNT_EN
        rst_n = 1'b0; #1;
        rst_n = 1'b1;
        tick();
        issue_valid = 1'b1; srca = 32'd5; srcb = 32'd6;
        tick();
        exp_prod = ref_prod(32'd5, 32'd6, issue_signed);
        issue_valid = 1'b0; mf_req = 1'b1;
        repeat (3) tick();
        mf_req = 1'b0; #1;
        `CHK("stall_cycles_3", stall_cycles, 3);
        rst_n = 1'b0; #1;
        `CHK("stall_cycles_rst", stall_cycles, 0);
        rst_n = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
